// File: rtl/led_pwm_driver_if.sv
// Duty-request handshake bundle for led_pwm_driver.
// master = requester, slave = PWM driver.
interface led_pwm_driver_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] duty;
  logic             duty_valid;
  logic             duty_ready;

  modport master (output duty, output duty_valid, input  duty_ready);
  modport slave  (input  duty, input  duty_valid, output duty_ready);
endinterface

// File: rtl/led_pwm_driver.sv
// LED PWM driver: free-running counter, glitch-free duty updates at period boundaries.
// Define LED_PWM_FADE_EN to step the active duty one LSB per period instead of jumping.
module led_pwm_driver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  led_pwm_driver_if.slave      req,
  output logic                 led_pad,
  output logic                 busy,
  output logic                 period_tick
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] APPLY = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] cur_next;
  logic             done;

  assign period_tick    = (cnt == '1);
  assign req.duty_ready = (state == IDLE);
  assign busy           = (state == APPLY);

  always_comb begin
    cur_next = tgt;
`ifdef LED_PWM_FADE_EN
    // Single-LSB step toward the target; equal values leave cur untouched.
    if (cur < tgt)
      cur_next = cur + 1'b1;
    else if (cur > tgt)
      cur_next = cur - 1'b1;
    else
      cur_next = cur;
`endif
    done = (cur_next == tgt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      cur     <= '0;
      tgt     <= '0;
      led_pad <= 1'b0;
      state   <= IDLE;
    end else begin
      cnt     <= cnt + 1'b1;
      led_pad <= (cnt < cur);
      case (state)
        IDLE: begin
          if (req.duty_valid) begin
            tgt   <= req.duty;
            state <= APPLY;
          end
        end
        APPLY: begin
          // cur only moves on the last cycle of a period so no period is cut short.
          if (period_tick) begin
            cur <= cur_next;
            if (done)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
